menu_btn_ctrl: RTL and testbench
================================

# menu_btn_ctrl

Single-clock button front end and menu-selection register for the ATM menu. Conditions the raw BTNU/BTND push-buttons (synchronise, debounce, edge-detect) in the `clk` domain and maintains the current menu item index. It drives the display mux select plus the per-item reset vector for the four instruction text generators (balance, withdraw, currency, transfer). This replaces clocking menu logic from a debounced button edge.

## Interface
Parameters:
- `DB_CYCLES`, 1_000_000: stable-input cycles required to accept a level change (10 ms at 100 MHz); minimum 2.
- `REPEAT_DELAY`, 50_000_000: held cycles before the first auto-repeat (used only with the macro).
- `REPEAT_PERIOD`, 20_000_000: cycles between subsequent auto-repeats (used only with the macro).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_up` in 1: raw BTNU, asynchronous, active-high.
- `btn_down` in 1: raw BTND, asynchronous, active-high.
- `sel` out 2: current menu item. 0 = balance, 1 = withdraw, 2 = currency, 3 = transfer.
- `inst_rst` out 4: active-high resets to the generators. Bit i resets item i.
- `sel_strobe` out 1: one-cycle pulse in the cycle `sel` takes a new value.

## Operation
- Each button has its own conditioner:
  - 2-FF synchroniser, reset 0.
  - Debounce counter: clears whenever the synchronised level equals the accepted level. Otherwise it increments. When it reaches `DB_CYCLES-1`, the accepted level takes the synchronised level and the counter clears.
  - Press pulse: one cycle on each accepted 0→1 transition. A release produces nothing.
- Selection update, registered:
  - Up pulse alone: `sel` = `sel-1`, wrapping 0→3.
  - Down pulse alone: `sel` = `sel+1`, wrapping 3→0.
  - Both pulses in the same cycle: no change and no strobe.
  - Neither pulse: hold.
- `sel_strobe` is registered. It is high in exactly the cycles where the `sel` register changes.
- `inst_rst` is registered:
  - In the strobe cycle: 4'b1111, so the newly selected generator restarts its text from the beginning.
  - Otherwise: bitwise NOT of onehot(`sel`). The selected item runs and all others are held in reset.
- Reset values (asynchronous on `rst_n` low):
  - `sel` = 0.
  - `sel_strobe` = 0.
  - `inst_rst` = 4'b1110. Item 0 runs, so bit 0 is low and bits 1–3 are high, per the NOT-onehot rule.
  - Synchronisers, accepted levels and all counters = 0.
- Reset asserted mid-debounce or mid-hold discards all partial counts. A button already held when reset releases is accepted as a press after the normal debounce time.
- Glitches shorter than `DB_CYCLES` cycles produce no pulse.

## Timing
- Input rising before clock edge E0 and stable thereafter:
  - The synchronised level is high after E1.
  - The accepted level is high `DB_CYCLES` edges later.
  - The press pulse is high in the following cycle.
  - `sel`, `sel_strobe` and `inst_rst` update on the edge after that.
- Total latency from the first sampling edge to `sel` change: `DB_CYCLES`+3 cycles, fixed and deterministic.
- `inst_rst` = 4'b1111 for exactly one cycle (coincident with `sel_strobe`), then settles to NOT-onehot of the new `sel`.
- Up and down conditioners are independent. Pulses from both buttons that are one cycle apart are applied in order: two strobes in two consecutive cycles.

## Configuration
- Macro: `MENU_BTN_REPEAT_EN`.
- Defined:
  - While a button's accepted level stays high, a hold counter runs.
  - An extra press pulse is generated after `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles, until release.
  - The hold counter clears on release and on reset.
  - Repeat pulses follow the same simultaneity and wrap rules as ordinary presses.
- Undefined: exactly one pulse per accepted press. Hold counters and the `REPEAT_*` parameters are absent from the logic.

## Structure
- `menu_pkg` holds:
  - `SEL_W` = 2 and `N_ITEMS` = 4.
  - Item constants `ITEM_BALANCE`, `ITEM_WITHDRAW`, `ITEM_CURRENCY`, `ITEM_TRANSFER`.
  - A `menu_item_t` typedef for `sel`.
- Sub-module `btn_conditioner`:
  - Contains the synchroniser, debounce counter, edge pulse, and optional repeat logic.
  - Instantiated twice (up and down).
  - Parameters: `DB_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`.
- Top level holds only the selection register, strobe, and `inst_rst` encode.

## Test plan
All scenarios use `DB_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- Reset, then idle 50 cycles -> `sel`=0, `inst_rst`=4'b1110, `sel_strobe` never high.
- Hold `btn_up` high 10 cycles from reset state:
  - `sel`=3 exactly 7 cycles after the first sampling edge.
  - One strobe cycle with `inst_rst`=4'b1111, then `inst_rst`=4'b0111.
  - No further change.
- Press `btn_down` 5 times from `sel`=2 -> `sel` sequence 3, 0, 1, 2, 3 with 5 strobes. Wrap 3→0 is verified.
- Bounce `btn_up` as 3-cycle high / 1-cycle low pulses for 40 cycles, then low -> no strobe, `sel` unchanged.
- Assert both buttons on the same cycle for 10 cycles -> simultaneous pulses, `sel` unchanged, no strobe. Assert `rst_n` low at cycle 3 of a debounce -> `sel`=0, counters cleared, no late pulse after release.
- With `MENU_BTN_REPEAT_EN` defined, hold `btn_down` 60 cycles from `sel`=0:
  - Pulses at acceptance, +20, +28, +36, +44, +52 cycles.
  - `sel` = 1, 2, 3, 0, 1, 2.
  - Without the macro, `sel`=1 only.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared menu definitions: selection width, item count and item encodings.
// Used by the button front end and menu-selection register.
package menu_pkg;

    localparam int SEL_W   = 2;
    localparam int N_ITEMS = 4;

    typedef enum logic [SEL_W-1:0] {
        ITEM_BALANCE  = 2'd0,
        ITEM_WITHDRAW = 2'd1,
        ITEM_CURRENCY = 2'd2,
        ITEM_TRANSFER = 2'd3
    } menu_item_t;

    // One-hot decode of an item index; bit i set for item i.
    function automatic logic [N_ITEMS-1:0] item_onehot(input logic [SEL_W-1:0] item);
        item_onehot = {{(N_ITEMS-1){1'b0}}, 1'b1} << item;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce, registered press pulse.
// Optional auto-repeat while held is enabled by defining MENU_BTN_REPEAT_EN.
module btn_conditioner #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

    // Reject nonsensical configurations at elaboration time.
    if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner: DB_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic             sync1_r;
    logic             sync_r;
    logic [CNT_W-1:0] db_cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             press_r;
    logic             rep_fire_s;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync_r  <= sync1_r;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= {CNT_W{1'b0}};
            level_r  <= 1'b0;
        end else if (sync_r == level_r) begin
            db_cnt_r <= {CNT_W{1'b0}};
            level_r  <= level_r;
        end else if (db_cnt_r == DB_MAX) begin
            db_cnt_r <= {CNT_W{1'b0}};
            level_r  <= sync_r;
        end else begin
            db_cnt_r <= db_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            level_r  <= level_r;
        end
    end

`ifdef MENU_BTN_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_V  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] PERIOD_V = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic              rep_phase_r;

    // Hold count equals cycles since acceptance; it restarts at 1 after each repeat.
    always_comb begin
        rep_fire_s = 1'b0;
        if (level_r) begin
            if (rep_phase_r) begin
                rep_fire_s = (hold_cnt_r == PERIOD_V);
            end else begin
                rep_fire_s = (hold_cnt_r == DELAY_V);
            end
        end else begin
            rep_fire_s = 1'b0;
        end
    end

    // Hold counter runs while the accepted level is high, clears on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r  <= {HOLD_W{1'b0}};
            rep_phase_r <= 1'b0;
        end else if (!level_r) begin
            hold_cnt_r  <= {HOLD_W{1'b0}};
            rep_phase_r <= 1'b0;
        end else if (rep_fire_s) begin
            hold_cnt_r  <= {{(HOLD_W-1){1'b0}}, 1'b1};
            rep_phase_r <= 1'b1;
        end else begin
            hold_cnt_r  <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
            rep_phase_r <= rep_phase_r;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Registered press pulse on each accepted rising level (plus any repeat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            level_d_r <= level_r;
            press_r   <= (level_r & ~level_d_r) | rep_fire_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/menu_btn_ctrl.sv
// ATM menu button front end: two conditioned buttons step the menu selection.
// Auto-repeat on hold is built in when MENU_BTN_REPEAT_EN is defined.
module menu_btn_ctrl
    import menu_pkg::*;
#(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] sel,
    output logic [3:0] inst_rst,
    output logic       sel_strobe
);

    logic               up_pulse_s;
    logic               down_pulse_s;
    menu_item_t         sel_r;
    menu_item_t         sel_next_s;
    logic               change_s;
    logic               sel_strobe_r;
    logic [N_ITEMS-1:0] inst_rst_r;

    btn_conditioner #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_up),
        .press(up_pulse_s)
    );

    btn_conditioner #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_down (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_down),
        .press(down_pulse_s)
    );

    // Next selection: up steps back, down steps forward, simultaneous presses cancel.
    always_comb begin
        sel_next_s = sel_r;
        change_s   = 1'b0;
        case ({up_pulse_s, down_pulse_s})
            2'b10: begin
                sel_next_s = menu_item_t'(sel_r - 2'd1);
                change_s   = 1'b1;
            end
            2'b01: begin
                sel_next_s = menu_item_t'(sel_r + 2'd1);
                change_s   = 1'b1;
            end
            default: begin
                sel_next_s = sel_r;
                change_s   = 1'b0;
            end
        endcase
    end

    // Selection register; all generators reset for the strobe cycle so the new item restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r        <= ITEM_BALANCE;
            sel_strobe_r <= 1'b0;
            inst_rst_r   <= ~item_onehot(ITEM_BALANCE);
        end else begin
            sel_r        <= sel_next_s;
            sel_strobe_r <= change_s;
            inst_rst_r   <= change_s ? {N_ITEMS{1'b1}} : ~item_onehot(sel_next_s);
        end
    end

    assign sel        = sel_r;
    assign sel_strobe = sel_strobe_r;
    assign inst_rst   = inst_rst_r;

endmodule

// File: tb/tb_menu_btn_ctrl.sv
// Directed self-checking bench for menu_btn_ctrl with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_menu_btn_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] sel;
    logic [3:0] inst_rst;
    logic       sel_strobe;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    int base;

    menu_btn_ctrl #(
        .DB_CYCLES    (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .sel       (sel),
        .inst_rst  (inst_rst),
        .sel_strobe(sel_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sel_strobe === 1'b1) strobes++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] not_onehot(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << s);
    endfunction

    task automatic press_btn(input bit up);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        cyc(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(12);
    endtask

    initial begin
        int exp_seq[5] = '{3, 0, 1, 2, 3};
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(3);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_inst", 32'(inst_rst), 32'he);
        chk("rst_strobe", 32'(sel_strobe), 32'd0);
        rst_n = 1'b1;
        cyc(50);
        chk("idle_sel", 32'(sel), 32'd0);
        chk("idle_inst", 32'(inst_rst), 32'he);
        chk("idle_strobes", 32'(strobes), 32'd0);

        // Up held 10 cycles: change exactly 7 edges after the first sampling edge.
        btn_up = 1'b1;
        cyc(7);
        chk("lat_sel_before", 32'(sel), 32'd0);
        cyc(1);
        chk("lat_sel_after", 32'(sel), 32'd3);
        chk("lat_strobe", 32'(sel_strobe), 32'd1);
        chk("lat_inst_all", 32'(inst_rst), 32'hf);
        cyc(1);
        chk("lat_strobe_off", 32'(sel_strobe), 32'd0);
        chk("lat_inst_settle", 32'(inst_rst), 32'h7);
        cyc(1);
        btn_up = 1'b0;
        cyc(20);
        chk("hold_sel", 32'(sel), 32'd3);
        chk("hold_strobes", 32'(strobes), 32'd1);

        press_btn(1'b1);
        chk("up_to_2", 32'(sel), 32'd2);

        // Five down presses including the 3->0 wrap.
        base = strobes;
        for (int i = 0; i < 5; i++) begin
            press_btn(1'b0);
            chk($sformatf("down_sel%0d", i), 32'(sel), 32'(exp_seq[i]));
            chk($sformatf("down_inst%0d", i), 32'(inst_rst), 32'(not_onehot(exp_seq[i])));
        end
        chk("down_strobes", 32'(strobes - base), 32'd5);

        // Bounce: 3 high / 1 low never survives the debounce.
        base = strobes;
        for (int i = 0; i < 10; i++) begin
            btn_up = 1'b1;
            cyc(3);
            btn_up = 1'b0;
            cyc(1);
        end
        cyc(20);
        chk("bounce_sel", 32'(sel), 32'd3);
        chk("bounce_strobes", 32'(strobes - base), 32'd0);

        // Both buttons together cancel.
        base = strobes;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cyc(10);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(15);
        chk("both_sel", 32'(sel), 32'd3);
        chk("both_strobes", 32'(strobes - base), 32'd0);

        // Reset in the middle of a debounce.
        base = strobes;
        btn_down = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_inst", 32'(inst_rst), 32'he);
        btn_down = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        chk("midrst_after_sel", 32'(sel), 32'd0);
        chk("midrst_strobes", 32'(strobes - base), 32'd0);

        // Button held across reset release is a normal press.
        rst_n  = 1'b0;
        btn_up = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(7);
        chk("heldrst_before", 32'(sel), 32'd0);
        cyc(1);
        chk("heldrst_after", 32'(sel), 32'd3);
        btn_up = 1'b0;
        cyc(15);

        press_btn(1'b0);
        chk("wrap_to_0", 32'(sel), 32'd0);

        // Long hold of down: auto-repeat only when enabled.
        base = strobes;
        btn_down = 1'b1;
        cyc(60);
        btn_down = 1'b0;
        cyc(20);
`ifdef MENU_BTN_REPEAT_EN
        chk("longhold_sel", 32'(sel), 32'd2);
        chk("longhold_strobes", 32'(strobes - base), 32'd6);
`else
        chk("longhold_sel", 32'(sel), 32'd1);
        chk("longhold_strobes", 32'(strobes - base), 32'd1);
`endif
        chk("longhold_inst", 32'(inst_rst), 32'(not_onehot(int'(sel))));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
